// File: rtl/pfpu_seq_pkg.sv
// Shared definitions for the PFPU program store and sequencer: state encoding and
// instruction word layout {a, b, op, w}, MSB first.
package pfpu_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    function automatic int instr_w(input int reg_w, input int op_w);
        return 3 * reg_w + op_w;
    endfunction

    function automatic int w_lsb(input int reg_w, input int op_w);
        return 0;
    endfunction

    function automatic int op_lsb(input int reg_w, input int op_w);
        return reg_w;
    endfunction

    function automatic int b_lsb(input int reg_w, input int op_w);
        return reg_w + op_w;
    endfunction

    function automatic int a_lsb(input int reg_w, input int op_w);
        return 2 * reg_w + op_w;
    endfunction

endpackage

// File: rtl/pfpu_seq_if.sv
// Sequencer bus: run control, instruction issue towards the datapath and the CSR
// program-store access port. master = CSR/scheduler side, slave = sequencer.
interface pfpu_seq_if #(
    parameter int PC_W    = 11,
    parameter int REG_W   = 7,
    parameter int OP_W    = 4,
    parameter int CPAGE_W = 2
);
    logic                      start;
    logic                      stall;
    logic [PC_W:0]             prog_len;
    logic                      busy;
    logic                      done;
    logic                      instr_valid;
    logic [REG_W-1:0]          a_addr;
    logic [REG_W-1:0]          b_addr;
    logic [REG_W-1:0]          w_addr;
    logic [OP_W-1:0]           opcode;
    logic [PC_W-1:0]           pc;
    logic                      par_err;
    logic                      c_en;
    logic [CPAGE_W-1:0]        c_page;
    logic [PC_W-CPAGE_W-1:0]   c_offset;
    logic                      c_w_en;
    logic [31:0]               c_di;
    logic [31:0]               c_do;

    modport master (
        output start, stall, prog_len, c_en, c_page, c_offset, c_w_en, c_di,
        input  busy, done, instr_valid, a_addr, b_addr, w_addr, opcode, pc, par_err, c_do
    );

    modport slave (
        input  start, stall, prog_len, c_en, c_page, c_offset, c_w_en, c_di,
        output busy, done, instr_valid, a_addr, b_addr, w_addr, opcode, pc, par_err, c_do
    );
endinterface

// File: rtl/pfpu_seq_ram.sv
// Single-port synchronous RAM with read enable; the output register holds its word
// while re is low so a stalled fetch keeps presenting the same instruction.
module pfpu_seq_ram #(
    parameter int W  = 25,
    parameter int AW = 11
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic          re,
    input  logic [AW-1:0] addr,
    input  logic [W-1:0]  di,
    output logic [W-1:0]  dout
);
    logic [W-1:0] mem [0:(1<<AW)-1];
    logic [W-1:0] dout_q, dout_d;

    // NOTE: the array itself is never reset (contents must survive a reset and a reset
    // loop would block RAM inference); only the output register is cleared.
    always_ff @(posedge clk) begin
        if (we) mem[addr] <= di;
    end

    always_comb begin
        dout_d = re ? mem[addr] : dout_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) dout_q <= '0;
        else        dout_q <= dout_d;
    end

    assign dout = dout_q;
endmodule

// File: rtl/pfpu_seq.sv
// PFPU program store and sequencer top. Optional fetch parity checking is enabled by
// defining PFPU_SEQ_PARITY_EN; the default build stores no parity and ties par_err low.
module pfpu_seq
    import pfpu_seq_pkg::*;
#(
    parameter int PC_W    = 11,
    parameter int REG_W   = 7,
    parameter int OP_W    = 4,
    parameter int CPAGE_W = 2
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    pfpu_seq_if.slave bus
);
    localparam int INSTR_W = instr_w(REG_W, OP_W);
`ifdef PFPU_SEQ_PARITY_EN
    localparam int RAM_W = INSTR_W + 1;
`else
    localparam int RAM_W = INSTR_W;
`endif
    localparam logic [PC_W:0] LEN_ONE = 1;

    state_e            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [PC_W:0]     len_q, len_d;
    logic              instr_valid_q, instr_valid_d;
    logic              done_q, done_d;
    logic              par_err_q, par_err_d;

    logic              idle;
    logic              ram_we, ram_re, par_bad;
    logic [PC_W-1:0]   ram_addr;
    logic [RAM_W-1:0]  ram_di, ram_do;

    assign idle = (state_q == ST_IDLE);

    always_comb begin
        ram_addr = (bus.c_en && idle) ? {bus.c_page, bus.c_offset} : pc_q;
        ram_we   = bus.c_en & bus.c_w_en & idle;
        ram_re   = ~bus.stall | idle;
`ifdef PFPU_SEQ_PARITY_EN
        ram_di   = {^bus.c_di[INSTR_W-1:0], bus.c_di[INSTR_W-1:0]};
        par_bad  = instr_valid_q & (^ram_do);
`else
        ram_di   = bus.c_di[INSTR_W-1:0];
        par_bad  = 1'b0;
`endif
    end

    pfpu_seq_ram #(.W(RAM_W), .AW(PC_W)) u_ram (
        .clk   (sys_clk),
        .rst_n (sys_rst_n),
        .we    (ram_we),
        .re    (ram_re),
        .addr  (ram_addr),
        .di    (ram_di),
        .dout  (ram_do)
    );

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples
    // the pre-edge value of its peers regardless of statement order.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state_q       <= ST_IDLE;
            pc_q          <= '0;
            len_q         <= '0;
            instr_valid_q <= 1'b0;
            done_q        <= 1'b0;
            par_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            len_q         <= len_d;
            instr_valid_q <= instr_valid_d;
            done_q        <= done_d;
            par_err_q     <= par_err_d;
        end
    end

    // NOTE: every variable gets a default before the case so no path leaves one
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        len_d         = len_q;
        instr_valid_d = instr_valid_q;
        done_d        = 1'b0;
        par_err_d     = par_err_q;

        // A fetched word with bad parity aborts the run whatever the stall state.
        if (par_bad) begin
            state_d       = ST_IDLE;
            pc_d          = '0;
            instr_valid_d = 1'b0;
            done_d        = 1'b1;
            par_err_d     = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        par_err_d = 1'b0;
                        if (bus.prog_len != '0) begin
                            state_d = ST_RUN;
                            len_d   = bus.prog_len;
                            pc_d    = '0;
                        end else begin
                            done_d  = 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (!bus.stall) begin
                        instr_valid_d = 1'b1;
                        pc_d          = pc_q + 1'b1;
                        if ({1'b0, pc_q} == len_q - LEN_ONE) state_d = ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (!bus.stall) begin
                        instr_valid_d = 1'b0;
                        done_d        = 1'b1;
                        state_d       = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        bus.busy        = !idle;
        bus.done        = done_q;
        bus.instr_valid = instr_valid_q & ~par_bad;
        bus.a_addr      = ram_do[a_lsb(REG_W, OP_W)  +: REG_W];
        bus.b_addr      = ram_do[b_lsb(REG_W, OP_W)  +: REG_W];
        bus.opcode      = ram_do[op_lsb(REG_W, OP_W) +: OP_W];
        bus.w_addr      = ram_do[w_lsb(REG_W, OP_W)  +: REG_W];
        bus.pc          = pc_q;
        bus.par_err     = par_err_q;
        bus.c_do        = 32'(ram_do[INSTR_W-1:0]);
    end
endmodule

// File: tb/tb_pfpu_seq.sv
// Self-checking bench for pfpu_seq: CSR load/readback table, directed run sequences
// and randomized runs scored against an array/queue model of the program store.
module tb_pfpu_seq;
    localparam int PC_W    = 11;
    localparam int REG_W   = 7;
    localparam int OP_W    = 4;
    localparam int CPAGE_W = 2;
    localparam int DEPTH   = 2048;
    localparam int IW      = 25;

    typedef struct {
        int          addr;
        logic [31:0] wdata;
        logic [31:0] exp_do;
    } csr_vec_t;

    logic sys_clk   = 1'b0;
    logic sys_rst_n = 1'b0;
    int   checks    = 0;
    int   failures  = 0;
    logic [IW-1:0] model_mem [DEPTH];

    pfpu_seq_if #(.PC_W(PC_W), .REG_W(REG_W), .OP_W(OP_W), .CPAGE_W(CPAGE_W)) bus ();

    pfpu_seq #(.PC_W(PC_W), .REG_W(REG_W), .OP_W(OP_W), .CPAGE_W(CPAGE_W)) u_dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .bus       (bus)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic csr_write(input int addr, input logic [31:0] d);
        logic [PC_W-1:0] a;
        a = PC_W'(addr);
        {bus.c_page, bus.c_offset} = a;
        bus.c_en = 1'b1; bus.c_w_en = 1'b1; bus.c_di = d;
        tick();
        bus.c_en = 1'b0; bus.c_w_en = 1'b0;
        model_mem[addr] = d[IW-1:0];
    endtask

    task automatic csr_read(input int addr, output logic [31:0] d);
        logic [PC_W-1:0] a;
        a = PC_W'(addr);
        {bus.c_page, bus.c_offset} = a;
        bus.c_en = 1'b1; bus.c_w_en = 1'b0;
        tick();
        bus.c_en = 1'b0;
        d = bus.c_do;
    endtask

    // Runs one program; the expected stream is simply model_mem[0..len-1] in order.
    task automatic run_prog(input string name, input int len, input int pct, input int s_from,
                            input int s_to, input int exp_first, input int exp_done, input bit noise);
        logic [IW-1:0] exp_q[$];
        logic [IW-1:0] cur, held_word;
        int  cyc, consumed, first_v, done_cyc;
        bit  held, sv;
        for (int i = 0; i < len; i++) exp_q.push_back(model_mem[i % DEPTH]);
        bus.prog_len = (PC_W+1)'(len);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check({name, " busy"}, bus.busy, 1);
        cyc = 1; consumed = 0; first_v = -1; done_cyc = -1; held = 0;
        while (cyc < len * 8 + 100) begin
            sv = (cyc >= s_from && cyc < s_to) || ($urandom_range(99) < pct);
            bus.stall = sv;
            if (bus.done) begin
                done_cyc = cyc;
                break;
            end
            if (held) check({name, " valid hold"}, bus.instr_valid, 1);
            if (bus.instr_valid) begin
                if (first_v < 0) first_v = cyc;
                cur = {bus.a_addr, bus.b_addr, bus.opcode, bus.w_addr};
                if (held) check({name, " frozen"}, cur, held_word);
                if (!sv) begin
                    if (exp_q.size() == 0) check({name, " overrun"}, 1, 0);
                    else check({name, " instr"}, cur, exp_q.pop_front());
                    consumed++;
                    held = 0;
                end else begin
                    held = 1;
                    held_word = cur;
                end
            end else begin
                held = 0;
            end
            if (noise) begin
                bus.start    = 1'($urandom);
                bus.prog_len = (PC_W+1)'($urandom);
                bus.c_en     = 1'($urandom);
                bus.c_w_en   = 1'b1;
                bus.c_page   = CPAGE_W'($urandom);
                bus.c_offset = (PC_W-CPAGE_W)'($urandom);
                bus.c_di     = $urandom;
            end
            tick();
            cyc++;
        end
        bus.start = 1'b0; bus.c_en = 1'b0; bus.c_w_en = 1'b0; bus.stall = 1'b0;
        check({name, " done seen"}, done_cyc > 0, 1);
        check({name, " consumed"}, consumed, len);
        check({name, " valid at done"}, bus.instr_valid, 0);
        check({name, " busy at done"}, bus.busy, 0);
        check({name, " par_err"}, bus.par_err, 0);
        if (exp_first >= 0) check({name, " first valid cycle"}, first_v, exp_first);
        if (exp_done >= 0) check({name, " done cycle"}, done_cyc, exp_done);
        tick();
        check({name, " done pulse"}, bus.done, 0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        csr_vec_t    tbl [6];
        logic [31:0] rd;
        int          len, addr, nvalid;

        tbl[0] = '{0,    32'h0000_0001, 32'h0000_0001};
        tbl[1] = '{1,    32'h0000_0002, 32'h0000_0002};
        tbl[2] = '{2,    32'h0000_0003, 32'h0000_0003};
        tbl[3] = '{3,    32'h0000_0004, 32'h0000_0004};
        tbl[4] = '{512,  32'h0ABC_DEF0, 32'h00BC_DEF0};
        tbl[5] = '{2047, 32'hFFFF_FFFF, 32'h01FF_FFFF};

        bus.start = 0; bus.stall = 0; bus.prog_len = '0; bus.c_en = 0; bus.c_w_en = 0;
        bus.c_page = '0; bus.c_offset = '0; bus.c_di = '0;
        repeat (3) tick();
        check("rst busy", bus.busy, 0);
        check("rst done", bus.done, 0);
        check("rst instr_valid", bus.instr_valid, 0);
        check("rst par_err", bus.par_err, 0);
        check("rst pc", bus.pc, 0);
        check("rst fields", {bus.a_addr, bus.b_addr, bus.opcode, bus.w_addr}, 0);
        sys_rst_n = 1'b1;
        tick();

        // Load: random background, then the table words, then read the table back.
        for (int i = 4; i < DEPTH; i++) csr_write(i, $urandom);
        foreach (tbl[i]) csr_write(tbl[i].addr, tbl[i].wdata);
        foreach (tbl[i]) begin
            csr_read(tbl[i].addr, rd);
            check($sformatf("readback[%0d]", tbl[i].addr), rd, tbl[i].exp_do);
        end

        run_prog("run4", 4, 0, 0, 0, 2, 6, 0);
        run_prog("stall3", 4, 0, 3, 6, 2, 9, 0);

        bus.prog_len = '0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("len0 done", bus.done, 1);
        check("len0 valid", bus.instr_valid, 0);
        check("len0 busy", bus.busy, 0);
        tick();
        check("len0 done pulse", bus.done, 0);

        run_prog("full", DEPTH, 0, 0, 0, 2, DEPTH + 2, 0);
        check("full pc wrap", bus.pc, 0);

        len = $urandom_range(5, 60);
        run_prog("rand nostall", len, 0, 0, 0, 2, len + 2, 0);
        for (int k = 0; k < 8; k++) run_prog($sformatf("rand%0d", k), $urandom_range(1, 80), 30, 0, 0, -1, -1, 1);
        for (int k = 0; k < 8; k++) begin
            addr = $urandom_range(0, DEPTH - 1);
            csr_read(addr, rd);
            check($sformatf("post-run readback[%0d]", addr), rd, 32'(model_mem[addr]));
        end

        // Reset in the middle of a run.
        bus.prog_len = 12'd100;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (6) tick();
        sys_rst_n = 1'b0;
        tick();
        check("midrst busy", bus.busy, 0);
        check("midrst valid", bus.instr_valid, 0);
        check("midrst done", bus.done, 0);
        check("midrst pc", bus.pc, 0);
        sys_rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("midrst no done", bus.done, 0);
        end
        for (int i = 0; i < 4; i++) begin
            csr_read(i, rd);
            check($sformatf("midrst readback[%0d]", i), rd, i + 1);
        end

`ifdef PFPU_SEQ_PARITY_EN
        u_dut.u_ram.mem[2] = u_dut.u_ram.mem[2] ^ 26'h000_0010;
        bus.prog_len = 12'd4;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        nvalid = 0;
        for (int c = 0; c < 30 && !bus.done; c++) begin
            if (bus.instr_valid) nvalid++;
            tick();
        end
        check("parity done", bus.done, 1);
        check("parity valids", nvalid, 2);
        check("parity par_err", bus.par_err, 1);
        check("parity busy", bus.busy, 0);
        tick();
        check("parity sticky", bus.par_err, 1);
        csr_write(2, 32'h3);
        run_prog("parity clear", 4, 0, 0, 0, 2, 6, 0);
`else
        nvalid = 0;
        check("no-parity par_err", bus.par_err, nvalid);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
